// File: rtl/risc_dmem_resp_if.sv
// CPU data-port and host preload bus for the data-memory responder.
interface risc_dmem_resp_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          dmenbl;
    logic          rdwr;
    logic [AW-1:0] dmaddr;
    logic [DW-1:0] dmdatain;
    logic [DW-1:0] dmdataout;
    logic          init_busy;
    logic          host_vld;
    logic          host_rdy;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic [7:0]    rd_cnt;
    logic [7:0]    wr_cnt;
    logic          coll_err;

    modport master (
        output dmenbl, rdwr, dmaddr, dmdatain, host_vld, host_addr, host_data,
        input  dmdataout, init_busy, host_rdy, rd_cnt, wr_cnt, coll_err
    );

    modport slave (
        input  dmenbl, rdwr, dmaddr, dmdatain, host_vld, host_addr, host_data,
        output dmdataout, init_busy, host_rdy, rd_cnt, wr_cnt, coll_err
    );
endinterface

// File: rtl/risc_dmem_resp.sv
// Data-memory target for the CPU eunit: 1-cycle registered reads, host preload
// port, saturating access counters and a post-reset zero-fill sequencer.
module risc_dmem_resp #(
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    risc_dmem_resp_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dout;
    logic [7:0]    rd_cnt;
    logic [7:0]    wr_cnt;
    logic          coll_err;

    logic cpu_rd, cpu_wr, host_rdy, host_wr;

    assign cpu_rd   = (state == IDLE) && bus.dmenbl && bus.rdwr;
    assign cpu_wr   = (state == IDLE) && bus.dmenbl && !bus.rdwr;
    assign host_rdy = (state == IDLE) && !bus.dmenbl;
    assign host_wr  = host_rdy && bus.host_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_CLEAR ? CLEAR : IDLE;
            ptr      <= '0;
            dout     <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            coll_err <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == AW'(DEPTH - 1))
                        state <= IDLE;
                    // CPU traffic during the clear is dropped but remembered
                    if (bus.dmenbl)
                        coll_err <= 1'b1;
                end
                IDLE: begin
                    if (cpu_rd) begin
                        dout <= mem[bus.dmaddr];
                        if (rd_cnt != 8'hFF)
                            rd_cnt <= rd_cnt + 8'd1;
                    end
                    if (cpu_wr && wr_cnt != 8'hFF)
                        wr_cnt <= wr_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU owns the array whenever it asserts dmenbl, so host and CPU writes
    // are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[ptr] <= '0;
            else if (cpu_wr)
                mem[bus.dmaddr] <= bus.dmdatain;
            else if (host_wr)
                mem[bus.host_addr] <= bus.host_data;
        end
    end

    assign bus.dmdataout = dout;
    assign bus.init_busy = (state == CLEAR);
    assign bus.host_rdy  = host_rdy;
    assign bus.rd_cnt    = rd_cnt;
    assign bus.wr_cnt    = wr_cnt;
    assign bus.coll_err  = coll_err;
endmodule

// File: tb/tb_risc_dmem_resp.sv
// Directed bench for risc_dmem_resp: vector table plus clear/reset sequences.
module tb_risc_dmem_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    risc_dmem_resp_if #(.AW(4), .DW(8)) bus ();

    risc_dmem_resp #(.AW(4), .DW(8), .INIT_CLEAR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       en;
        logic       rw;
        logic [3:0] addr;
        logic [7:0] data;
        logic       hv;
        logic [3:0] ha;
        logic [7:0] hd;
        logic       exp_rdy;
        logic [7:0] exp_dout;
        logic [7:0] exp_rd;
        logic [7:0] exp_wr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.dmenbl = 1'b0; bus.rdwr = 1'b0; bus.dmaddr = '0; bus.dmdatain = '0;
        bus.host_vld = 1'b0; bus.host_addr = '0; bus.host_data = '0;
    endtask

    // Counts cycles with init_busy high, starting from the current sample.
    task automatic wait_busy(output int n);
        n = 0;
        while (bus.init_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic cpu_read(input logic [3:0] a);
        bus.dmenbl = 1'b1; bus.rdwr = 1'b1; bus.dmaddr = a;
        tick();
        bus.dmenbl = 1'b0;
    endtask

    task automatic do_reset_and_clear();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_busy(n);
        check("reset_clear_len", n, 16);
    endtask

    initial begin
        int n;
        idle_bus();

        // 1: reset state, clear length, all words zero
        tick();
        tick();
        rst = 1'b0;
        check("rst_dout", bus.dmdataout, 8'h00);
        check("rst_rd_cnt", bus.rd_cnt, 8'd0);
        check("rst_wr_cnt", bus.wr_cnt, 8'd0);
        check("rst_coll", bus.coll_err, 1'b0);
        check("rst_busy", bus.init_busy, 1'b1);
        check("clear_host_rdy", bus.host_rdy, 1'b0);
        wait_busy(n);
        check("init_clear_len", n, 16);
        check("idle_busy", bus.init_busy, 1'b0);
        for (int a = 0; a < 16; a++) begin
            cpu_read(4'(a));
            check($sformatf("init_zero[%0d]", a), bus.dmdataout, 8'h00);
        end

        // 2/3: host preload, CPU priority, write-then-read, counters
        do_reset_and_clear();
        vecs[0]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3, 8'hA5, 1'b1, 8'h00, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'd3,  8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'hA5, 8'd1, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 4'd15, 8'h3C, 1'b1, 4'd4, 8'h77, 1'b0, 8'hA5, 8'd1, 8'd1};
        vecs[3]  = '{1'b1, 1'b1, 4'd15, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h3C, 8'd2, 8'd1};
        vecs[4]  = '{1'b1, 1'b1, 4'd4,  8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'd3, 8'd1};
        vecs[5]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h00, 8'd3, 8'd1};
        vecs[6]  = '{1'b1, 1'b0, 4'd0,  8'h5A, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'd3, 8'd2};
        vecs[7]  = '{1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h5A, 8'd4, 8'd2};
        vecs[8]  = '{1'b0, 1'b1, 4'd3,  8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h5A, 8'd4, 8'd2};
        vecs[9]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd0, 8'h11, 1'b1, 8'h5A, 8'd4, 8'd2};
        vecs[10] = '{1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h11, 8'd5, 8'd2};
        vecs[11] = '{1'b1, 1'b1, 4'd3,  8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 8'hA5, 8'd6, 8'd2};
        for (int i = 0; i < 12; i++) begin
            bus.dmenbl = vecs[i].en;   bus.rdwr = vecs[i].rw;
            bus.dmaddr = vecs[i].addr; bus.dmdatain = vecs[i].data;
            bus.host_vld = vecs[i].hv; bus.host_addr = vecs[i].ha; bus.host_data = vecs[i].hd;
            #1;
            check($sformatf("v%0d_host_rdy", i), bus.host_rdy, vecs[i].exp_rdy);
            tick();
            check($sformatf("v%0d_dout", i), bus.dmdataout, vecs[i].exp_dout);
            check($sformatf("v%0d_rd_cnt", i), bus.rd_cnt, vecs[i].exp_rd);
            check($sformatf("v%0d_wr_cnt", i), bus.wr_cnt, vecs[i].exp_wr);
        end
        idle_bus();
        check("v_coll", bus.coll_err, 1'b0);

        // 5: read counter saturation
        do_reset_and_clear();
        bus.dmenbl = 1'b1; bus.rdwr = 1'b1; bus.dmaddr = 4'd7;
        repeat (300) tick();
        check("sat_rd_cnt", bus.rd_cnt, 8'd255);
        check("sat_wr_cnt", bus.wr_cnt, 8'd0);
        tick();
        check("sat_rd_hold", bus.rd_cnt, 8'd255);
        idle_bus();

        // 6 (+4): fill with 0xFF, collide during clear, reset mid-clear
        for (int a = 0; a < 16; a++) begin
            bus.host_vld = 1'b1; bus.host_addr = 4'(a); bus.host_data = 8'hFF;
            tick();
        end
        idle_bus();
        cpu_read(4'd9);
        check("fill_ff", bus.dmdataout, 8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        cpu_read(4'd2);
        check("coll_set", bus.coll_err, 1'b1);
        check("coll_dout", bus.dmdataout, 8'h00);
        check("coll_rd_cnt", bus.rd_cnt, 8'd0);
        repeat (3) tick();
        check("coll_sticky", bus.coll_err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_coll", bus.coll_err, 1'b0);
        check("mid_rst_dout", bus.dmdataout, 8'h00);
        check("mid_rst_busy", bus.init_busy, 1'b1);
        repeat (5) tick();
        bus.dmenbl = 1'b1; bus.rdwr = 1'b0; bus.dmaddr = 4'd0; bus.dmdatain = 8'hEE;
        tick();
        idle_bus();
        wait_busy(n);
        check("restart_clear_rest", n, 10);
        check("coll_wr_cnt", bus.wr_cnt, 8'd0);
        for (int a = 0; a < 16; a++) begin
            cpu_read(4'(a));
            check($sformatf("reclear_zero[%0d]", a), bus.dmdataout, 8'h00);
        end
        check("reclear_rd_cnt", bus.rd_cnt, 8'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
